// File: rtl/mb8_console.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mb8_console: memory-mapped 8N1 serial transmit console with a TX FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module mb8_console #(
  parameter logic [16:0] BASE     = 17'h1FFF0,
  parameter int          BAUD_DIV = 16,
  parameter int          DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] ai,
  input  logic        we,
  input  logic [7:0]  vi,
  output logic [7:0]  vo,
  output logic        sel_o,
  output logic        txd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, en_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    vo_q;
  logic          sel_q, txd_q;

  logic          hit, rd, wr_txd, wr_ctrl, rd_status, flush;
  logic          full, empty, busy, baud_end, pop, push, drop;
  logic [8:0]    count_ext;
  logic [7:0]    status, rdata;

  always_comb begin
    hit       = (ai[16:2] == BASE[16:2]);
    rd        = hit & ~we;
    wr_txd    = hit & we & (ai[1:0] == 2'd0);
    wr_ctrl   = hit & we & (ai[1:0] == 2'd2);
    rd_status = rd & (ai[1:0] == 2'd1);
    flush     = wr_ctrl & vi[7];
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    busy      = (state_q != S_IDLE);
    baud_end  = (baud_q == BAUD_LAST);
    // A new frame may start from IDLE or straight out of the last STOP cycle.
    pop       = en_q & ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_end));
    push      = wr_txd & ~full;
    drop      = wr_txd & full;
    ovf_d     = drop | (ovf_q & ~rd_status);
    count_d   = count_q;
    if (push & ~pop)
      count_d = count_q + CW'(1);
    else if (pop & ~push)
      count_d = count_q - CW'(1);
    count_ext = 9'(count_q);
    status    = {4'b0000, ovf_q, busy, empty, full};
    case (ai[1:0])
      2'd1:    rdata = status;
      2'd2:    rdata = {7'b0000000, en_q};
      2'd3:    rdata = (count_ext > 9'd255) ? 8'hFF : count_ext[7:0];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wp_q] <= vi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vo_q    <= '0;
      sel_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      vo_q  <= rd ? rdata : 8'h00;
      sel_q <= rd;
      ovf_q <= ovf_d;
      if (wr_ctrl)
        en_q <= vi[0];
      if (flush) begin
        wp_q    <= '0;
        rp_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + PW'(1);
        if (pop)  rp_q <= rp_q + PW'(1);
        count_q <= count_d;
      end

      // Line level lags the state by one cycle so txd is a clean register output.
      case (state_q)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rp_q];
            baud_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7)
              state_q <= S_STOP;
            else
              bit_q <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rp_q];
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vo    = vo_q;
  assign sel_o = sel_q;
  assign txd   = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_mb8_console.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mb8_console: directed + randomized bench for mb8_console. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mb8_console;

  localparam logic [16:0] BASE  = 17'h1FFF0;
  localparam int          BD    = 4;
  localparam int          DEPTH = 4;
  localparam logic [16:0] PARK  = BASE ^ 17'h00100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] ai    = PARK;
  logic        we    = 1'b0;
  logic [7:0]  vi    = 8'h00;
  logic [7:0]  vo;
  logic        sel_o;
  logic        txd;

  int checks = 0;
  int errors = 0;

  mb8_console #(.BASE(BASE), .BAUD_DIV(BD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ai(ai), .we(we), .vi(vi),
    .vo(vo), .sel_o(sel_o), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level model: a byte queue plus the position inside the frame on the wire.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_en = 1'b1, m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_vo = 8'h00;
  logic       exp_sel = 1'b0, exp_txd = 1'b1;
  logic       m_hit, m_start, m_end;
  logic [1:0] m_off;
  int         m_sz;

  function automatic logic line_level(input int pos, input logic [7:0] b);
    int slot;
    slot = pos / BD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_act = 1'b0; m_pos = 0;
      exp_vo = 8'h00; exp_sel = 1'b0; exp_txd = 1'b1;
    end else begin
      m_hit   = (ai[16:2] == BASE[16:2]);
      m_off   = ai[1:0];
      m_sz    = mq.size();
      exp_sel = m_hit && !we;
      exp_vo  = 8'h00;
      if (exp_sel) begin
        case (m_off)
          2'd1:    exp_vo = {4'b0000, m_ovf, m_act, m_sz == 0, m_sz == DEPTH};
          2'd2:    exp_vo = {7'b0000000, m_en};
          2'd3:    exp_vo = (m_sz > 255) ? 8'hFF : 8'(m_sz);
          default: exp_vo = 8'h00;
        endcase
      end
      exp_txd = m_act ? line_level(m_pos, m_byte) : 1'b1;
      m_end   = m_act && (m_pos == 10*BD - 1);
      m_start = (!m_act || m_end) && m_en && (m_sz > 0);
      if (m_start) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_pos  = 0;
      end else if (m_end) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_pos++;
      end
      if (m_hit && !we && m_off == 2'd1) m_ovf = 1'b0;
      if (m_hit && we && m_off == 2'd0) begin
        if (m_sz == DEPTH) m_ovf = 1'b1;
        else mq.push_back(vi);
      end
      if (m_hit && we && m_off == 2'd2) begin
        m_en = vi[0];
        if (vi[7]) mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("vo", 32'(vo), 32'(exp_vo));
    chk("sel_o", 32'(sel_o), 32'(exp_sel));
    chk("txd", 32'(txd), 32'(exp_txd));
  end

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
    ai = BASE | {15'b0, off}; we = 1'b1; vi = d;
    @(negedge clk);
    ai = PARK; we = 1'b0; vi = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
    ai = BASE | {15'b0, off}; we = 1'b0;
    @(negedge clk);
    d = vo;
    ai = PARK;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [0:9]  p41;
    logic [0:19] p2;
    logic [16:0] a;
    logic [1:0]  off;
    int          lows;

    p41 = 10'b0100000101;
    p2  = 20'b0101010101_0010101011;

    repeat (3) @(negedge clk);
    chk("reset_vo", 32'(vo), 32'h0);
    chk("reset_sel", 32'(sel_o), 32'h0);
    chk("reset_txd", 32'(txd), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 'h41 frame with a mid-frame STATUS read.
    bus_write(2'd0, 8'h41);
    @(negedge clk);
    chk("txd_latency_high", 32'(txd), 32'h1);
    for (int i = 0; i < 10*BD; i++) begin
      @(negedge clk);
      chk("frame41", 32'(txd), 32'(p41[i/BD]));
      if (i == 10) begin ai = BASE | 17'd1; we = 1'b0; end
      if (i == 11) begin
        chk("status_busy", 32'(vo), 32'h06);
        chk("status_busy_sel", 32'(sel_o), 32'h1);
        ai = PARK;
      end
    end
    @(negedge clk);
    chk("after41_txd", 32'(txd), 32'h1);
    bus_read(2'd1, d);
    chk("after41_status", 32'(d), 32'h02);

    // Overflow with transmit disabled.
    bus_write(2'd2, 8'h00);
    for (int i = 0; i <= DEPTH; i++) bus_write(2'd0, 8'(i + 1));
    bus_read(2'd3, d);
    chk("count_full", 32'(d), 32'(DEPTH));
    bus_read(2'd1, d);
    chk("status_ovf", 32'(d), 32'h09);
    bus_read(2'd1, d);
    chk("status_ovf_cleared", 32'(d), 32'h01);
    bus_write(2'd2, 8'h81);
    bus_read(2'd3, d);
    chk("count_after_flush", 32'(d), 32'h0);
    bus_read(2'd2, d);
    chk("ctrl_read", 32'(d), 32'h01);

    // Two back-to-back frames, no gap.
    bus_write(2'd0, 8'h55);
    bus_write(2'd0, 8'hAA);
    for (int i = 0; i < 20*BD; i++) begin
      @(negedge clk);
      chk("frames55AA", 32'(txd), 32'(p2[i/BD]));
    end
    @(negedge clk);
    chk("after55AA_txd", 32'(txd), 32'h1);

    // Flush during the first of three queued frames.
    bus_write(2'd0, 8'h0F);
    bus_write(2'd0, 8'h33);
    bus_write(2'd0, 8'hC3);
    repeat (10) @(negedge clk);
    bus_write(2'd2, 8'h81);
    bus_read(2'd3, d);
    chk("flush_count", 32'(d), 32'h0);
    repeat (30) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 15*BD; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("post_flush_idle", 32'(lows), 32'h0);
    bus_read(2'd1, d);
    chk("post_flush_status", 32'(d), 32'h02);

    // Reset during DATA bit 3 ('h35 has bit3 = 0).
    bus_write(2'd0, 8'h35);
    bus_write(2'd0, 8'h5A);
    repeat (18) @(negedge clk);
    chk("pre_reset_bit3", 32'(txd), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_txd", 32'(txd), 32'h1);
    chk("reset_async_sel", 32'(sel_o), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d);
    chk("post_reset_status", 32'(d), 32'h02);
    lows = 0;
    for (int i = 0; i < 15*BD; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("post_reset_idle", 32'(lows), 32'h0);

    // Window read followed by an outside address.
    ai = BASE | 17'd1; we = 1'b0;
    @(negedge clk);
    chk("win_sel", 32'(sel_o), 32'h1);
    chk("win_vo", 32'(vo), 32'h02);
    ai = PARK;
    @(negedge clk);
    chk("out_sel", 32'(sel_o), 32'h0);
    chk("out_vo", 32'(vo), 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 45) begin
        a = 17'($urandom);
        if (a[16:2] == BASE[16:2]) a[8] = ~a[8];
        ai = a; we = 1'($urandom); vi = 8'($urandom);
      end else begin
        off = 2'($urandom_range(0, 3));
        ai = BASE | {15'b0, off}; we = 1'($urandom); vi = 8'($urandom);
        if (off == 2'd2 && we) begin
          vi[0] = ($urandom_range(0, 3) != 0);
          vi[7] = ($urandom_range(0, 7) == 0);
        end
      end
      if (c == 2000) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    ai = PARK; we = 1'b0; vi = 8'h00;
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mb8_console.md
MB8_CONSOLE -- requirements
Module: mb8_console

Interface
REQ-001 The block SHALL have parameter BASE, default 'h1FFF0, the 17-bit base address of the register window; its two LSBs are 0.
REQ-002 The block SHALL have parameter BAUD_DIV, default 16, the number of clk cycles per serial bit (minimum 2).
REQ-003 The block SHALL have parameter DEPTH, default 16, the TX FIFO entries (power of 2, 2..256).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port ai, input, 17 bits: the byte address from the bus master.
REQ-007 The block SHALL have port we, input, 1 bit: write enable; 0 means read.
REQ-008 The block SHALL have port vi, input, 8 bits: write data.
REQ-009 The block SHALL have port vo, output, 8 bits: registered read data.
REQ-010 The block SHALL have port sel_o, output, 1 bit: registered; 1 when vo carries data from this block.
REQ-011 The block SHALL have port txd, output, 1 bit: the serial line, idle high.

Function
REQ-012 The block SHALL decode its window as ai[16:2]==BASE[16:2]; addresses outside the window SHALL cause no state change.
REQ-013 The register map SHALL be:
- +0 TXD: a write pushes vi; a read returns 0.
- +1 STATUS (read-only): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits7:4 = 0.
- +2 CTRL: bit0 enable (R/W); writing bit7=1 flushes (self-clearing, reads 0).
- +3 COUNT (read-only): the FIFO occupancy, saturating at 255.
REQ-014 Reads SHALL have 1-cycle latency: ai sampled at edge N gives vo/sel_o valid after edge N; outside the window vo=0 and sel_o=0.
REQ-015 A TXD write with the FIFO full at the start of the cycle SHALL drop the byte and set overflow, even if a pop occurs in the same cycle.
REQ-016 A read of STATUS SHALL clear overflow after returning it; if a drop occurs in the same cycle, overflow SHALL stay 1.
REQ-017 A flush SHALL empty the FIFO at that edge without aborting the frame in progress; a TXD write in the same cycle SHALL be discarded without setting overflow.
REQ-018 The FIFO SHALL be circular, with read/write pointers wrapping modulo DEPTH and count in 0..DEPTH.
REQ-019 The TX FSM SHALL have states IDLE, START, DATA, STOP; txd SHALL be 1 in IDLE, 0 in START, the current data bit in DATA and 1 in STOP.
REQ-020 In IDLE, if enable=1 and the FIFO is non-empty (registered), the FSM SHALL pop the head into the shift register and enter START at the next edge.
REQ-021 Each of START, each DATA bit and STOP SHALL last exactly BAUD_DIV cycles.
REQ-022 DATA SHALL send 8 bits, LSB first, so a frame is 10*BAUD_DIV cycles.
REQ-023 At the end of STOP, if enable=1 and the FIFO is non-empty, the FSM SHALL pop and enter START directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-024 Clearing enable mid-frame SHALL let the current frame complete and then prevent further pops.
REQ-025 A write to the TXD slot at edge E0 with the FSM idle and the FIFO empty SHALL drive txd low from edge E0+2.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: vo=0, sel_o=0, txd=1, FSM=IDLE, FIFO empty, pointers 0, overflow=0, enable=1, baud and bit counters 0.
REQ-027 A reset mid-frame SHALL abort the frame with txd=1 at once; after release, no byte pushed before reset is sent.
REQ-028 Release of rst_n SHALL take effect on the first rising edge of clk after deassertion.

Verification
REQ-029 With BAUD_DIV=4, write 'h41 to BASE+0: txd low 4 cycles, then bits 1,0,0,0,0,0,1,0 of 4 cycles each, then high 4 cycles; busy=1 throughout, then 0.
REQ-030 Write DEPTH+1 bytes back-to-back with enable=0: COUNT reads DEPTH and STATUS reads 'h09; a second STATUS read returns 'h01.
REQ-031 Queue 'h55 and 'hAA with enable=1: the two frames are contiguous, 80 cycles total at BAUD_DIV=4, with no idle high gap between STOP and START.
REQ-032 Flush while the first of 3 queued bytes is transmitting: that frame completes, COUNT reads 0, and txd stays high afterwards.
REQ-033 Assert rst_n during DATA bit 3: txd=1 immediately, STATUS reads 'h02 after release, and no further frames are sent.
REQ-034 Read BASE+1 and then an address outside the window: sel_o=1 with STATUS data one cycle later, followed by sel_o=0 and vo=0.
